// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, register-map and flush signals of the reorder buffer.
// The ROB uses the slave modport; the environment drives through master.
interface reorder_buffer_if #(
  parameter int unsigned ROB_DEPTH      = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  localparam int unsigned TAG_WIDTH = $clog2(ROB_DEPTH);

  logic                      i_rob_enq_en;
  logic [REG_ADDR_WIDTH-1:0] i_rob_enq_rdest;
  logic                      o_rob_full;
  logic                      o_regmap_rename_en;
  logic [REG_ADDR_WIDTH-1:0] o_regmap_rename_rdest;
  logic [TAG_WIDTH-1:0]      o_regmap_rename_tag;
  logic                      i_cdb_en;
  logic [TAG_WIDTH-1:0]      i_cdb_tag;
  logic [DATA_WIDTH-1:0]     i_cdb_data;
  logic                      i_cdb_redirect;
  logic [DATA_WIDTH-1:0]     i_cdb_redirect_addr;
  logic                      o_regmap_retire_en;
  logic [REG_ADDR_WIDTH-1:0] o_regmap_retire_rdest;
  logic [TAG_WIDTH-1:0]      o_regmap_retire_tag;
  logic [DATA_WIDTH-1:0]     o_regmap_retire_data;
  logic                      o_flush;
  logic [DATA_WIDTH-1:0]     o_redirect_addr;

  modport master (
    output i_rob_enq_en, i_rob_enq_rdest,
    output i_cdb_en, i_cdb_tag, i_cdb_data, i_cdb_redirect, i_cdb_redirect_addr,
    input  o_rob_full, o_regmap_rename_en, o_regmap_rename_rdest, o_regmap_rename_tag,
    input  o_regmap_retire_en, o_regmap_retire_rdest, o_regmap_retire_tag,
    input  o_regmap_retire_data, o_flush, o_redirect_addr
  );

  modport slave (
    input  i_rob_enq_en, i_rob_enq_rdest,
    input  i_cdb_en, i_cdb_tag, i_cdb_data, i_cdb_redirect, i_cdb_redirect_addr,
    output o_rob_full, o_regmap_rename_en, o_regmap_rename_rdest, o_regmap_rename_tag,
    output o_regmap_retire_en, o_regmap_retire_rdest, o_regmap_retire_tag,
    output o_regmap_retire_data, o_flush, o_redirect_addr
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at dispatch, collects CDB results
// out of order, retires from the head and flushes on a mispredicted producer.
module reorder_buffer #(
  parameter int unsigned ROB_DEPTH      = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave rob
);
  localparam int unsigned TAG_WIDTH = $clog2(ROB_DEPTH);
  localparam int unsigned CNT_WIDTH = TAG_WIDTH + 1;

  logic [ROB_DEPTH-1:0]      r_rdy;
  logic [ROB_DEPTH-1:0]      r_redirect;
  logic [REG_ADDR_WIDTH-1:0] r_rdest         [ROB_DEPTH];
  logic [DATA_WIDTH-1:0]     r_data          [ROB_DEPTH];
  logic [DATA_WIDTH-1:0]     r_redirect_addr [ROB_DEPTH];
  logic [TAG_WIDTH-1:0]      r_head;
  logic [TAG_WIDTH-1:0]      r_tail;
  logic [CNT_WIDTH-1:0]      r_count;

  logic                 w_full;
  logic                 w_retire;
  logic                 w_flush;
  logic                 w_enq;
  logic [TAG_WIDTH-1:0] w_cdb_off;
  logic                 w_cdb_hit;

  assign w_full   = (r_count == CNT_WIDTH'(ROB_DEPTH));
  assign w_retire = (r_count != '0) & r_rdy[r_head];
  assign w_flush  = w_retire & r_redirect[r_head];
  assign w_enq    = rob.i_rob_enq_en & ~w_full & ~w_flush & ~rst;

  // Tag is occupied when its distance from head (mod depth) is below the count.
  assign w_cdb_off = rob.i_cdb_tag - r_head;
  assign w_cdb_hit = rob.i_cdb_en & ({1'b0, w_cdb_off} < r_count);

  assign rob.o_rob_full            = w_full;
  assign rob.o_regmap_rename_en    = w_enq & (rob.i_rob_enq_rdest != '0);
  assign rob.o_regmap_rename_rdest = rob.i_rob_enq_rdest;
  assign rob.o_regmap_rename_tag   = r_tail;

  assign rob.o_regmap_retire_en    = w_retire & (r_rdest[r_head] != '0);
  assign rob.o_regmap_retire_tag   = w_retire ? r_head : '0;
  assign rob.o_regmap_retire_rdest = w_retire ? r_rdest[r_head] : '0;
  assign rob.o_regmap_retire_data  = w_retire ? r_data[r_head] : '0;
  assign rob.o_flush               = w_flush;
  assign rob.o_redirect_addr       = w_flush ? r_redirect_addr[r_head] : '0;

  // Control state; a flush empties the buffer exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rdy      <= '0;
      r_redirect <= '0;
    end else begin
      if (w_cdb_hit) begin
        r_rdy[rob.i_cdb_tag]      <= 1'b1;
        r_redirect[rob.i_cdb_tag] <= rob.i_cdb_redirect;
      end
      if (w_enq) begin
        r_rdy[r_tail]      <= 1'b0;
        r_redirect[r_tail] <= 1'b0;
        r_tail             <= r_tail + TAG_WIDTH'(1);
      end
      if (w_retire) begin
        r_head <= r_head + TAG_WIDTH'(1);
      end
      r_count <= r_count + CNT_WIDTH'(w_enq) - CNT_WIDTH'(w_retire);
    end
  end

  // Payload storage needs no reset: validity is tracked by count and rdy.
  always_ff @(posedge clk) begin
    if (!rst && !w_flush) begin
      if (w_cdb_hit) begin
        r_data[rob.i_cdb_tag]          <= rob.i_cdb_data;
        r_redirect_addr[rob.i_cdb_tag] <= rob.i_cdb_redirect_addr;
      end
      if (w_enq) begin
        r_rdest[r_tail] <= rob.i_rob_enq_rdest;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, hand-written
// full/reset sequences and random traffic against a queue-based model.
module tb_reorder_buffer;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned RW    = 5;

  typedef struct {
    bit          rst;
    bit          enq;
    logic [4:0]  rdest;
    bit          ce;
    logic [2:0]  ctag;
    logic [31:0] cdata;
    bit          red;
    logic [31:0] raddr;
  } ins_t;

  typedef struct {
    bit          full;
    bit          ren;
    logic [2:0]  rtag;
    bit          reten;
    logic [2:0]  rettag;
    logic [4:0]  retrdest;
    logic [31:0] retdata;
    bit          flush;
    logic [31:0] raddr;
  } outs_t;

  typedef struct {
    ins_t  i;
    outs_t o;
  } vec_t;

  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  rdest;
    bit          rdy;
    logic [31:0] data;
    bit          red;
    logic [31:0] addr;
  } ment_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  vec_t tbl[$];
  ment_t mq[$];
  int   m_tail;

  reorder_buffer_if #(.ROB_DEPTH(DEPTH), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) rob_if ();

  reorder_buffer #(.ROB_DEPTH(DEPTH), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .rob (rob_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ins_t vi(bit r, bit e, int rd, bit ce, int ct, logic [31:0] cd,
                              bit red, logic [31:0] ra);
    ins_t x;
    x.rst = r; x.enq = e; x.rdest = 5'(rd); x.ce = ce; x.ctag = 3'(ct);
    x.cdata = cd; x.red = red; x.raddr = ra;
    return x;
  endfunction

  function automatic outs_t vo(bit f, bit ren, int rt, bit ret, int rett, int retrd,
                               logic [31:0] retd, bit fl, logic [31:0] ra);
    outs_t o;
    o.full = f; o.ren = ren; o.rtag = 3'(rt); o.reten = ret; o.rettag = 3'(rett);
    o.retrdest = 5'(retrd); o.retdata = retd; o.flush = fl; o.raddr = ra;
    return o;
  endfunction

  task automatic add(input ins_t i, input outs_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string nm, input outs_t e);
    chk({nm, ".full"},        64'(rob_if.o_rob_full),            64'(e.full));
    chk({nm, ".rename_en"},   64'(rob_if.o_regmap_rename_en),    64'(e.ren));
    chk({nm, ".rename_tag"},  64'(rob_if.o_regmap_rename_tag),   64'(e.rtag));
    chk({nm, ".retire_en"},   64'(rob_if.o_regmap_retire_en),    64'(e.reten));
    chk({nm, ".retire_tag"},  64'(rob_if.o_regmap_retire_tag),   64'(e.rettag));
    chk({nm, ".retire_rd"},   64'(rob_if.o_regmap_retire_rdest), 64'(e.retrdest));
    chk({nm, ".retire_data"}, 64'(rob_if.o_regmap_retire_data),  64'(e.retdata));
    chk({nm, ".flush"},       64'(rob_if.o_flush),               64'(e.flush));
    chk({nm, ".redir_addr"},  64'(rob_if.o_redirect_addr),       64'(e.raddr));
  endtask

  // Drive one cycle's inputs after the falling edge, then let outputs settle.
  task automatic apply(input ins_t x);
    @(negedge clk);
    rst                        = x.rst;
    rob_if.i_rob_enq_en        = x.enq;
    rob_if.i_rob_enq_rdest     = x.rdest;
    rob_if.i_cdb_en            = x.ce;
    rob_if.i_cdb_tag           = x.ctag;
    rob_if.i_cdb_data          = x.cdata;
    rob_if.i_cdb_redirect      = x.red;
    rob_if.i_cdb_redirect_addr = x.raddr;
    #1;
  endtask

  function automatic outs_t model_out(input ins_t x);
    outs_t o;
    bit    ret;
    o = vo(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    ret     = (mq.size() > 0) && mq[0].rdy;
    o.full  = (mq.size() == DEPTH);
    o.flush = ret && mq[0].red;
    o.ren   = !x.rst && x.enq && !o.full && !o.flush && (x.rdest != 0);
    o.rtag  = 3'(m_tail);
    if (ret) begin
      o.reten    = (mq[0].rdest != 0);
      o.rettag   = mq[0].tag;
      o.retrdest = mq[0].rdest;
      o.retdata  = mq[0].data;
    end
    if (o.flush) o.raddr = mq[0].addr;
    return o;
  endfunction

  task automatic model_step(input ins_t x);
    bit    ret;
    bit    fl;
    bit    acc;
    ment_t n;
    ret = (mq.size() > 0) && mq[0].rdy;
    fl  = ret && mq[0].red;
    if (x.rst || fl) begin
      mq.delete();
      m_tail = 0;
    end else begin
      if (x.ce) begin
        foreach (mq[k]) begin
          if (mq[k].tag == x.ctag) begin
            mq[k].rdy  = 1'b1;
            mq[k].data = x.cdata;
            mq[k].red  = x.red;
            mq[k].addr = x.raddr;
          end
        end
      end
      acc = x.enq && (mq.size() < DEPTH);
      if (ret) void'(mq.pop_front());
      if (acc) begin
        n.tag = 3'(m_tail); n.rdest = x.rdest; n.rdy = 1'b0;
        n.data = 32'h0; n.red = 1'b0; n.addr = 32'h0;
        mq.push_back(n);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  initial begin
    ins_t  idle;
    ins_t  x;
    outs_t e;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    rob_if.i_rob_enq_en = 1'b0;  rob_if.i_rob_enq_rdest = '0;
    rob_if.i_cdb_en = 1'b0;      rob_if.i_cdb_tag = '0;
    rob_if.i_cdb_data = '0;      rob_if.i_cdb_redirect = 1'b0;
    rob_if.i_cdb_redirect_addr = '0;
    idle = vi(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);

    // Directed table: {inputs, expected combinational outputs} per cycle.
    add(vi(1, 1, 3, 1, 0, 32'h1, 0, 0),          vo(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(vi(0, 1, 5, 0, 0, 0, 0, 0),              vo(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(vi(0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0),   vo(0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(idle,                                    vo(0, 0, 1, 1, 0, 5, 32'hDEADBEEF, 0, 0));
    add(idle,                                    vo(0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(vi(1, 1, 7, 1, 1, 32'h99, 0, 0),         vo(0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(vi(0, 1, 1, 0, 0, 0, 0, 0),              vo(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(vi(0, 1, 2, 0, 0, 0, 0, 0),              vo(0, 1, 1, 0, 0, 0, 0, 0, 0));
    add(vi(0, 1, 3, 0, 0, 0, 0, 0),              vo(0, 1, 2, 0, 0, 0, 0, 0, 0));
    add(vi(0, 0, 0, 1, 2, 32'h22, 0, 0),         vo(0, 0, 3, 0, 0, 0, 0, 0, 0));
    add(vi(0, 0, 0, 1, 1, 32'h11, 0, 0),         vo(0, 0, 3, 0, 0, 0, 0, 0, 0));
    add(vi(0, 0, 0, 1, 0, 32'h10, 0, 0),         vo(0, 0, 3, 0, 0, 0, 0, 0, 0));
    add(idle,                                    vo(0, 0, 3, 1, 0, 1, 32'h10, 0, 0));
    add(idle,                                    vo(0, 0, 3, 1, 1, 2, 32'h11, 0, 0));
    add(idle,                                    vo(0, 0, 3, 1, 2, 3, 32'h22, 0, 0));
    add(idle,                                    vo(0, 0, 3, 0, 0, 0, 0, 0, 0));
    add(vi(1, 0, 0, 0, 0, 0, 0, 0),              vo(0, 0, 3, 0, 0, 0, 0, 0, 0));
    add(vi(0, 1, 4, 0, 0, 0, 0, 0),              vo(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(vi(0, 1, 5, 0, 0, 0, 0, 0),              vo(0, 1, 1, 0, 0, 0, 0, 0, 0));
    add(vi(0, 1, 6, 0, 0, 0, 0, 0),              vo(0, 1, 2, 0, 0, 0, 0, 0, 0));
    add(vi(0, 1, 7, 0, 0, 0, 0, 0),              vo(0, 1, 3, 0, 0, 0, 0, 0, 0));
    add(vi(0, 0, 0, 1, 1, 32'h55, 1, 32'h100),   vo(0, 0, 4, 0, 0, 0, 0, 0, 0));
    add(vi(0, 0, 0, 1, 0, 32'h44, 0, 0),         vo(0, 0, 4, 0, 0, 0, 0, 0, 0));
    add(idle,                                    vo(0, 0, 4, 1, 0, 4, 32'h44, 0, 0));
    add(vi(0, 1, 9, 1, 2, 32'h66, 0, 0),         vo(0, 0, 4, 1, 1, 5, 32'h55, 1, 32'h100));
    add(idle,                                    vo(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(vi(0, 0, 0, 1, 2, 32'h77, 0, 0),         vo(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(idle,                                    vo(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(vi(0, 1, 0, 0, 0, 0, 0, 0),              vo(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(vi(0, 0, 0, 1, 0, 32'hAB, 0, 0),         vo(0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(idle,                                    vo(0, 0, 1, 0, 0, 0, 32'hAB, 0, 0));
    add(vi(0, 1, 8, 0, 0, 0, 0, 0),              vo(0, 1, 1, 0, 0, 0, 0, 0, 0));
    add(vi(0, 0, 0, 1, 1, 32'h1, 0, 0),          vo(0, 0, 2, 0, 0, 0, 0, 0, 0));
    add(idle,                                    vo(0, 0, 2, 1, 1, 8, 32'h1, 0, 0));

    apply(vi(1, 0, 0, 0, 0, 0, 0, 0));
    apply(vi(1, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[k]) begin
      apply(tbl[k].i);
      check_all($sformatf("tbl%0d", k), tbl[k].o);
    end

    // Fill to full, refuse while full (even alongside a retire), then tag 0 is reused.
    apply(vi(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      apply(vi(0, 1, i + 1, 0, 0, 0, 0, 0));
      chk($sformatf("fill%0d.full", i), 64'(rob_if.o_rob_full), 64'd0);
      chk($sformatf("fill%0d.ren", i),  64'(rob_if.o_regmap_rename_en), 64'd1);
      chk($sformatf("fill%0d.tag", i),  64'(rob_if.o_regmap_rename_tag), 64'(i));
    end
    apply(vi(0, 1, 9, 0, 0, 0, 0, 0));
    chk("full9.full", 64'(rob_if.o_rob_full), 64'd1);
    chk("full9.ren",  64'(rob_if.o_regmap_rename_en), 64'd0);
    apply(vi(0, 1, 9, 1, 0, 32'h5, 0, 0));
    chk("fullcdb.ren",   64'(rob_if.o_regmap_rename_en), 64'd0);
    chk("fullcdb.reten", 64'(rob_if.o_regmap_retire_en), 64'd0);
    apply(vi(0, 1, 9, 0, 0, 0, 0, 0));
    chk("fullret.reten", 64'(rob_if.o_regmap_retire_en), 64'd1);
    chk("fullret.rd",    64'(rob_if.o_regmap_retire_rdest), 64'd1);
    chk("fullret.full",  64'(rob_if.o_rob_full), 64'd1);
    chk("fullret.ren",   64'(rob_if.o_regmap_rename_en), 64'd0);
    apply(vi(0, 1, 10, 0, 0, 0, 0, 0));
    chk("afterret.full", 64'(rob_if.o_rob_full), 64'd0);
    chk("afterret.ren",  64'(rob_if.o_regmap_rename_en), 64'd1);
    chk("afterret.tag",  64'(rob_if.o_regmap_rename_tag), 64'd0);

    // Reset with five entries in flight.
    apply(vi(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      apply(vi(0, 1, i + 11, 0, 0, 0, 0, 0));
      chk($sformatf("rfill%0d.tag", i), 64'(rob_if.o_regmap_rename_tag), 64'(i));
    end
    apply(vi(1, 1, 3, 0, 0, 0, 0, 0));
    chk("rst1.ren", 64'(rob_if.o_regmap_rename_en), 64'd0);
    apply(vi(1, 1, 3, 0, 0, 0, 0, 0));
    check_all("rsthold", vo(0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(vi(0, 1, 6, 0, 0, 0, 0, 0));
    chk("postrst.full", 64'(rob_if.o_rob_full), 64'd0);
    chk("postrst.ren",  64'(rob_if.o_regmap_rename_en), 64'd1);
    chk("postrst.tag",  64'(rob_if.o_regmap_rename_tag), 64'd0);
    apply(vi(0, 0, 0, 1, 3, 32'h33, 0, 0));
    apply(idle);
    chk("staletag3.reten", 64'(rob_if.o_regmap_retire_en), 64'd0);
    apply(vi(0, 0, 0, 1, 0, 32'hC0DE, 0, 0));
    apply(idle);
    check_all("postrst.ret", vo(0, 0, 1, 1, 0, 6, 32'hC0DE, 0, 0));
    apply(idle);
    chk("postrst.empty", 64'(rob_if.o_regmap_retire_en), 64'd0);

    // Random traffic against the queue model.
    apply(vi(1, 0, 0, 0, 0, 0, 0, 0));
    mq.delete();
    m_tail = 0;
    for (int c = 0; c < 2000; c++) begin
      x.rst   = ($urandom_range(0, 149) == 0);
      x.enq   = ($urandom_range(0, 9) < 6);
      x.rdest = 5'($urandom_range(0, 31));
      x.ce    = ($urandom_range(0, 1) == 1);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        x.ctag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        x.ctag = 3'($urandom_range(0, DEPTH - 1));
      x.cdata = $urandom;
      x.red   = ($urandom_range(0, 15) == 0);
      x.raddr = $urandom;
      e = model_out(x);
      apply(x);
      check_all($sformatf("rnd%0d", c), e);
      model_step(x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
